// File: rtl/aes_subbytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_subbytes_seq
// Purpose  : Multi-cycle AES SubBytes / InvSubBytes engine. A 128-bit state is
//            accepted over a valid/ready handshake and LANES bytes are
//            substituted per clock, using a combinational GF(2^8) inverse per
//            lane shared between the forward and inverse transforms. The
//            result is held on a registered, back-pressurable output.
// Ports    : clk, rst_n (async assert, active-low)
//            in_valid/in_ready/in_data[127:0]/in_mode   : input handshake
//            out_valid/out_ready/out_data[127:0]/out_mode: output handshake
//            busy                                        : high while BUSY
//            Byte 0 is [127:120], byte 15 is [7:0]. in_mode 1 = inverse.
// Revision : 1.0 - initial release
// ============================================================================
module aes_subbytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_mode,
   output logic         busy
);

   localparam int CHUNKS = 16 / LANES;
   localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int CW     = 8 * LANES;
   localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [127:0]   work;
   logic [127:0]   work_nx;
   logic [KW-1:0]  k;
   logic           mode;
   logic           accept;
   logic           finish;
   logic [CW-1:0]  chunk_in;
   logic [CW-1:0]  chunk_sub;

   // ---------------------------------------------------------------- GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // a^254 as the product a^2 * a^4 * ... * a^128; yields 0 for a = 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // One inverter per lane: inverse mode applies the inverse affine before
   // the inversion, forward mode applies the affine after it.
   function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic inv);
      logic [7:0] pre;
      logic [7:0] b;
      pre = inv ? (rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05) : x;
      b   = gf_inv(pre);
      return inv ? b : (b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63);
   endfunction

   // ---------------------------------------------------------------- lanes
   // The work register is rotated left one chunk per BUSY cycle, so the chunk
   // being processed is always at the top. After CHUNKS rotations every byte
   // is back in its original position, matching in-place substitution.
   assign chunk_in = work[127 -: CW];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign chunk_sub[CW-1-8*l -: 8] = sbox_lane(chunk_in[CW-1-8*l -: 8], mode);
   end

   if (LANES == 16) begin : g_full
      assign work_nx = chunk_sub;
   end else begin : g_rot
      assign work_nx = {work[127-CW:0], chunk_sub};
   end

   // ---------------------------------------------------------------- FSM
   assign accept = in_valid & in_ready;
   assign finish = (state == BUSY) && (k == K_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (finish) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // A new block may be accepted in the same cycle the result leaves.
            in_ready  = out_ready;
            if (out_ready) state_nx = in_valid ? BUSY : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work     <= '0;
         k        <= '0;
         mode     <= 1'b0;
         out_data <= '0;
         out_mode <= 1'b0;
      end else begin
         if (accept) begin
            work <= in_data;
            mode <= in_mode;
            k    <= '0;
         end else if (state == BUSY) begin
            work <= work_nx;
            k    <= k + KW'(1);
         end
         if (finish) begin
            out_data <= work_nx;
            out_mode <= mode;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_subbytes_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aes_subbytes_seq
// Purpose  : Self-checking bench for aes_subbytes_seq. Five instances with
//            LANES = 1, 2, 4, 8, 16; index 2 (LANES = 4) is the main target.
//            A golden S-box is built by brute-force field inversion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_subbytes_seq;

   localparam int NDUT = 5;
   localparam int MAIN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         iv   [NDUT];
   logic         ir   [NDUT];
   logic [127:0] id   [NDUT];
   logic         im   [NDUT];
   logic         ov   [NDUT];
   logic         ordy [NDUT];
   logic [127:0] od   [NDUT];
   logic         om   [NDUT];
   logic         bz   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      aes_subbytes_seq #(.LANES(1 << g)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (iv[g]),
         .in_ready (ir[g]),
         .in_data  (id[g]),
         .in_mode  (im[g]),
         .out_valid(ov[g]),
         .out_ready(ordy[g]),
         .out_data (od[g]),
         .out_mode (om[g]),
         .busy     (bz[g])
      );
   end

   int compared   = 0;
   int mismatched = 0;

   // ---------------------------------------------------------------- model
   logic [7:0] sbox_t  [256];
   logic [7:0] isbox_t [256];

   function automatic logic [7:0] m_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] b;
      logic [7:0] s;
      for (int a = 0; a < 256; a++) begin
         b = 8'h00;
         for (int c = 1; c < 256; c++)
            if (m_mul(8'(a), 8'(c)) == 8'h01) b = 8'(c);
         s = b ^ m_rl(b, 1) ^ m_rl(b, 2) ^ m_rl(b, 3) ^ m_rl(b, 4) ^ 8'h63;
         sbox_t[a]  = s;
         isbox_t[s] = 8'(a);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      logic [7:0]   bt;
      for (int j = 0; j < 16; j++) begin
         bt = d[127-8*j -: 8];
         r[127-8*j -: 8] = inv ? isbox_t[bt] : sbox_t[bt];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- checks
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   logic [128:0] sbq [NDUT][4];
   int           wp  [NDUT];
   int           rp  [NDUT];

   task automatic monitor();
      logic [128:0] e;
      for (int i = 0; i < NDUT; i++) begin
         if (ov[i] && ordy[i]) begin
            if (wp[i] == rp[i]) begin
               compared++;
               mismatched++;
               $display("FAIL sb_underflow dut%0d: got output %h, required none", i, od[i]);
            end else begin
               e = sbq[i][rp[i] % 4];
               rp[i]++;
               chk($sformatf("sb_data dut%0d", i), od[i], e[127:0]);
               chk($sformatf("sb_mode dut%0d", i), 128'(om[i]), 128'(e[128]));
            end
         end
         if (iv[i] && ir[i]) begin
            sbq[i][wp[i] % 4] = {im[i], model(id[i], im[i])};
            wp[i]++;
         end
      end
   endtask

   // Called just after a rising edge; samples handshakes then advances one edge.
   task automatic cycle();
      #1;
      monitor();
      @(posedge clk);
      #1;
   endtask

   // Accept one block on instance i, measure latency, check result, consume it.
   task automatic run_block(input int i, input logic [127:0] din, input logic mode,
                            input logic [127:0] exp, input int lat, input string name);
      int n;
      iv[i] = 1'b1; id[i] = din; im[i] = mode; ordy[i] = 1'b1;
      #1;
      chk({name, " in_ready"}, 128'(ir[i]), 128'(1));
      cycle();
      iv[i] = 1'b0;
      id[i] = {$urandom, $urandom, $urandom, $urandom};
      im[i] = ~mode;
      n = 0;
      while (!ov[i] && n < 64) begin
         cycle();
         n++;
      end
      chk({name, " latency"}, 128'(n), 128'(lat));
      chk({name, " data"}, od[i], exp);
      chk({name, " mode"}, 128'(om[i]), 128'(mode));
      cycle();
   endtask

   typedef struct {
      logic [127:0] din;
      logic         mode;
      logic [127:0] dout;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [127:0] a_blk, b_blk, hold, c_blk;
      int n, base_w, base_r, cyc;

      vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      vecs[2] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
      vecs[3] = '{{16{8'hFF}}, 1'b0, {16{8'h16}}};
      vecs[4] = '{{16{8'h53}}, 1'b0, {16{8'hED}}};
      vecs[5] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};

      for (int i = 0; i < NDUT; i++) begin
         iv[i] = 1'b0; id[i] = '0; im[i] = 1'b0; ordy[i] = 1'b1;
         wp[i] = 0; rp[i] = 0;
      end
      build_tables();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset
      for (int c = 0; c < 20; c++) begin
         chk("idle in_ready", 128'(ir[MAIN]), 128'(1));
         chk("idle out_valid", 128'(ov[MAIN]), 128'(0));
         chk("idle out_data", od[MAIN], 128'(0));
         cycle();
      end
      chk("idle busy", 128'(bz[MAIN]), 128'(0));
      chk("idle out_mode", 128'(om[MAIN]), 128'(0));

      // Table vectors on LANES = 4
      for (int v = 0; v < 6; v++)
         run_block(MAIN, vecs[v].din, vecs[v].mode, vecs[v].dout, 4, $sformatf("vec%0d", v));

      // Inverse round trip on the other lane counts
      for (int i = 0; i < NDUT; i++) begin
         if (i != MAIN)
            run_block(i, vecs[1].din, 1'b1, vecs[1].dout, 16 >> i, $sformatf("inv_l%0d", 1 << i));
      end

      // Back-pressure then same-cycle accept from DONE
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      b_blk = {$urandom, $urandom, $urandom, $urandom};
      iv[MAIN] = 1'b1; id[MAIN] = a_blk; im[MAIN] = 1'b0; ordy[MAIN] = 1'b0;
      cycle();
      iv[MAIN] = 1'b0;
      n = 0;
      while (!ov[MAIN] && n < 64) begin
         cycle();
         n++;
      end
      chk("bp latency", 128'(n), 128'(4));
      hold = od[MAIN];
      for (int c = 0; c < 10; c++) begin
         iv[MAIN] = 1'b1; id[MAIN] = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("bp in_ready", 128'(ir[MAIN]), 128'(0));
         chk("bp out_valid", 128'(ov[MAIN]), 128'(1));
         chk("bp data", od[MAIN], model(a_blk, 1'b0));
         chk("bp stable", od[MAIN], hold);
         cycle();
      end
      id[MAIN] = b_blk; im[MAIN] = 1'b1; ordy[MAIN] = 1'b1;
      #1;
      chk("b2b in_ready", 128'(ir[MAIN]), 128'(1));
      cycle();
      iv[MAIN] = 1'b0;
      chk("b2b out_valid drop", 128'(ov[MAIN]), 128'(0));
      chk("b2b busy", 128'(bz[MAIN]), 128'(1));
      n = 0;
      while (!ov[MAIN] && n < 64) begin
         cycle();
         n++;
      end
      chk("b2b latency", 128'(n), 128'(4));
      chk("b2b data", od[MAIN], model(b_blk, 1'b1));
      chk("b2b mode", 128'(om[MAIN]), 128'(1));
      cycle();

      // Throughput: valid and ready held high gives one block per 5 cycles
      base_w = wp[MAIN];
      iv[MAIN] = 1'b1; ordy[MAIN] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         id[MAIN] = {$urandom, $urandom, $urandom, $urandom};
         im[MAIN] = 1'($urandom);
         cycle();
      end
      iv[MAIN] = 1'b0;
      chk("throughput accepts", 128'(wp[MAIN] - base_w), 128'(10));
      repeat (6) cycle();

      // Random streaming, 1000 blocks
      base_w = wp[MAIN];
      base_r = rp[MAIN];
      cyc = 0;
      while ((rp[MAIN] - base_r) < 1000 && cyc < 40000) begin
         iv[MAIN]   = ((wp[MAIN] - base_w) < 1000) && ($urandom_range(3) != 0);
         id[MAIN]   = {$urandom, $urandom, $urandom, $urandom};
         im[MAIN]   = 1'($urandom);
         ordy[MAIN] = ($urandom_range(2) != 0);
         cycle();
         cyc++;
      end
      iv[MAIN] = 1'b0; ordy[MAIN] = 1'b1;
      chk("stream blocks out", 128'(rp[MAIN] - base_r), 128'(1000));
      repeat (6) cycle();

      // Async reset while k = 2
      c_blk = {$urandom, $urandom, $urandom, $urandom};
      iv[MAIN] = 1'b1; id[MAIN] = c_blk; im[MAIN] = 1'b0; ordy[MAIN] = 1'b1;
      cycle();
      iv[MAIN] = 1'b0;
      cycle();
      cycle();
      chk("pre-reset busy", 128'(bz[MAIN]), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst busy", 128'(bz[MAIN]), 128'(0));
      chk("rst out_valid", 128'(ov[MAIN]), 128'(0));
      chk("rst out_data", od[MAIN], 128'(0));
      chk("rst in_ready", 128'(ir[MAIN]), 128'(1));
      for (int c = 0; c < 6; c++) begin
         cycle();
         chk("rst hold out_valid", 128'(ov[MAIN]), 128'(0));
      end
      for (int i = 0; i < NDUT; i++) rp[i] = wp[i];
      rst_n = 1'b1;
      cycle();
      c_blk = {$urandom, $urandom, $urandom, $urandom};
      run_block(MAIN, c_blk, 1'b0, model(c_blk, 1'b0), 4, "post-reset");

      for (int i = 0; i < NDUT; i++)
         chk($sformatf("sb_left dut%0d", i), 128'(wp[i] - rp[i]), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
